sent_rx_decoder: RTL and testbench

SENT_RX_DECODER -- requirements
Module: sent_rx_decoder

---
 rtl/sent_pkg.sv | 28 ++
 rtl/sent_rx_tick_meas.sv | 69 ++++++
 rtl/sent_rx_decoder.sv | 138 +++++++++++++
 tb/tb_sent_rx_decoder.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/sent_pkg.sv
// Shared constants, CRC table, decoder state type and CRC step helper for the SENT receiver.
package sent_pkg;

  localparam logic [6:0] SYNC_TICKS    = 7'd56;
  localparam logic [6:0] NIB_MIN_TICKS = 7'd12;
  localparam logic [6:0] NIB_MAX_TICKS = 7'd27;
  localparam logic [6:0] TICK_SAT      = 7'd127;
  localparam logic [3:0] CRC_SEED      = 4'h5;

  // x^4+x^3+x^2+1 lookup, indexed by the running CRC.
  localparam logic [3:0] CRC_TABLE [16] = '{
    4'd0, 4'd13, 4'd7, 4'd10, 4'd14, 4'd3, 4'd9, 4'd4,
    4'd1, 4'd12, 4'd6, 4'd11, 4'd15, 4'd2, 4'd8, 4'd5
  };

  typedef enum logic [2:0] {
    StIdle,
    StSync,
    StStatus,
    StData,
    StCrc
  } sent_state_e;

  function automatic logic [3:0] crc4_step(input logic [3:0] crc, input logic [3:0] nibble);
    return nibble ^ CRC_TABLE[crc];
  endfunction

endpackage

// File: rtl/sent_rx_tick_meas.sv
// Synchronizes the SENT line, detects falling edges and measures the interval between
// consecutive edges as a rounded, saturating tick count.
module sent_rx_tick_meas
  import sent_pkg::*;
#(
  parameter int unsigned TICK_CLKS = 50
) (
  input  logic       clk_rx,
  input  logic       reset_n_rx,
  input  logic       i_sent,
  output logic       o_edge,
  output logic [6:0] o_ticks,
  output logic       o_sat
);

  localparam int unsigned     SubW    = $clog2(TICK_CLKS);
  localparam logic [SubW-1:0] SubHalf = SubW'(TICK_CLKS / 2);
  localparam logic [SubW-1:0] SubLast = SubW'(TICK_CLKS - 1);

  logic            r_sync1;
  logic            r_sync2;
  logic            r_prev;
  logic [SubW-1:0] r_sub;
  logic [6:0]      r_tick;
  logic            r_edge;
  logic [6:0]      r_ticks_out;
  logic            r_sat;

  logic            w_edge;
  logic            w_wrap;
  logic [6:0]      w_tick_inc;

  assign w_edge = r_prev & ~r_sync2;
  assign w_wrap = (r_sub == SubLast);
  // Includes this cycle's increment so an interval of N clocks rounds to N/TICK_CLKS.
  assign w_tick_inc = (w_wrap && (r_tick != TICK_SAT)) ? r_tick + 7'd1 : r_tick;

  always_ff @(posedge clk_rx or negedge reset_n_rx) begin
    if (!reset_n_rx) begin
      r_sync1     <= 1'b1;
      r_sync2     <= 1'b1;
      r_prev      <= 1'b1;
      r_sub       <= '0;
      r_tick      <= '0;
      r_edge      <= 1'b0;
      r_ticks_out <= '0;
      r_sat       <= 1'b0;
    end else begin
      r_sync1     <= i_sent;
      r_sync2     <= r_sync1;
      r_prev      <= r_sync2;
      r_edge      <= w_edge;
      r_ticks_out <= w_tick_inc;
      r_sat       <= !w_edge && w_wrap && (r_tick == TICK_SAT - 7'd1);
      if (w_edge) begin
        r_sub  <= SubHalf;
        r_tick <= '0;
      end else begin
        r_sub  <= w_wrap ? '0 : r_sub + 1'b1;
        r_tick <= w_tick_inc;
      end
    end
  end

  assign o_edge  = r_edge;
  assign o_ticks = r_ticks_out;
  assign o_sat   = r_sat;

endmodule

// File: rtl/sent_rx_decoder.sv
// SENT frame receiver: classifies measured intervals, assembles status/data nibbles,
// checks the CRC and reports good frames, CRC errors and framing errors.
module sent_rx_decoder
  import sent_pkg::*;
#(
  parameter int unsigned TICK_CLKS = 50
) (
  input  logic        clk_rx,
  input  logic        reset_n_rx,
  input  logic        sent_i,
  output logic [3:0]  status_o,
  output logic [23:0] data_o,
  output logic        valid_o,
  output logic        crc_err_o,
  output logic        frame_err_o
);

  logic        w_edge;
  logic        w_sat;
  logic [6:0]  w_ticks;
  logic        w_is_sync;
  logic        w_is_nib;
  logic [3:0]  w_nib;
  logic        w_nib_bad;
  logic        w_sync_bad;

  sent_state_e r_state;
  logic [2:0]  r_nib_idx;
  logic [3:0]  r_crc;
  logic [3:0]  r_status_buf;
  logic [23:0] r_data_buf;
  logic        r_expect_sync;
  logic [3:0]  r_status;
  logic [23:0] r_data;
  logic        r_valid;
  logic        r_crc_err;
  logic        r_frame_err;

  sent_rx_tick_meas #(
    .TICK_CLKS(TICK_CLKS)
  ) u_tick_meas (
    .clk_rx    (clk_rx),
    .reset_n_rx(reset_n_rx),
    .i_sent    (sent_i),
    .o_edge    (w_edge),
    .o_ticks   (w_ticks),
    .o_sat     (w_sat)
  );

  assign w_is_sync = (w_ticks == SYNC_TICKS);
  assign w_is_nib  = (w_ticks >= NIB_MIN_TICKS) && (w_ticks <= NIB_MAX_TICKS);
  assign w_nib     = 4'(w_ticks - NIB_MIN_TICKS);
  // Saturation is an illegal interval as soon as it happens, without waiting for an edge.
  assign w_nib_bad  = w_sat || (w_edge && !w_is_nib);
  assign w_sync_bad = w_sat || (w_edge && !w_is_sync);

  always_ff @(posedge clk_rx or negedge reset_n_rx) begin
    if (!reset_n_rx) begin
      r_state       <= StIdle;
      r_nib_idx     <= '0;
      r_crc         <= '0;
      r_status_buf  <= '0;
      r_data_buf    <= '0;
      r_expect_sync <= 1'b0;
      r_status      <= '0;
      r_data        <= '0;
      r_valid       <= 1'b0;
      r_crc_err     <= 1'b0;
      r_frame_err   <= 1'b0;
    end else begin
      r_valid     <= 1'b0;
      r_crc_err   <= 1'b0;
      r_frame_err <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_edge) r_state <= StSync;
        end
        StSync: begin
          if (w_edge && w_is_sync) begin
            r_state       <= StStatus;
            r_expect_sync <= 1'b0;
          end
        end
        StStatus: begin
          // After a CRC nibble the first interval seen here must be the next sync.
          if (r_expect_sync ? w_sync_bad : w_nib_bad) begin
            r_frame_err <= 1'b1;
            r_state     <= StSync;
          end else if (w_edge) begin
            if (r_expect_sync) begin
              r_expect_sync <= 1'b0;
            end else begin
              r_status_buf <= w_nib;
              r_crc        <= CRC_SEED;
              r_nib_idx    <= '0;
              r_state      <= StData;
            end
          end
        end
        StData: begin
          if (w_nib_bad) begin
            r_frame_err <= 1'b1;
            r_state     <= StSync;
          end else if (w_edge) begin
            r_data_buf <= {r_data_buf[19:0], w_nib};
            r_crc      <= crc4_step(r_crc, w_nib);
            if (r_nib_idx == 3'd5) r_state <= StCrc;
            else r_nib_idx <= r_nib_idx + 3'd1;
          end
        end
        StCrc: begin
          if (w_nib_bad) begin
            r_frame_err <= 1'b1;
            r_state     <= StSync;
          end else if (w_edge) begin
            if (w_nib == CRC_TABLE[r_crc]) begin
              r_status <= r_status_buf;
              r_data   <= r_data_buf;
              r_valid  <= 1'b1;
            end else begin
              r_crc_err <= 1'b1;
            end
            r_expect_sync <= 1'b1;
            r_state       <= StStatus;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign status_o    = r_status;
  assign data_o      = r_data;
  assign valid_o     = r_valid;
  assign crc_err_o   = r_crc_err;
  assign frame_err_o = r_frame_err;

endmodule

// File: tb/tb_sent_rx_decoder.sv
// Scoreboard bench for sent_rx_decoder: drives SENT frames, queues expected outcomes and
// compares them with the output pulses as they appear.
module tb_sent_rx_decoder;

  localparam int unsigned TickClks = 50;
  localparam int KValid = 0;
  localparam int KCrc   = 1;
  localparam int KFrame = 2;
  localparam int KNone  = 3;
  localparam logic [3:0] CrcTab [16] = '{
    4'd0, 4'd13, 4'd7, 4'd10, 4'd14, 4'd3, 4'd9, 4'd4,
    4'd1, 4'd12, 4'd6, 4'd11, 4'd15, 4'd2, 4'd8, 4'd5
  };

  typedef struct {
    int          kind;
    logic [3:0]  st;
    logic [23:0] data;
  } exp_t;

  logic        clk_rx = 1'b0;
  logic        reset_n_rx = 1'b0;
  logic        sent_i = 1'b1;
  logic [3:0]  status_o;
  logic [23:0] data_o;
  logic        valid_o;
  logic        crc_err_o;
  logic        frame_err_o;

  int          n_checks = 0;
  int          n_errors = 0;
  exp_t        exp_q[$];
  logic [3:0]  good_st = 4'h0;
  logic [23:0] good_data = 24'h0;
  time         t_fall = 0;
  exp_t        mon_e;
  int          mon_kind;

  sent_rx_decoder #(
    .TICK_CLKS(TickClks)
  ) dut (
    .clk_rx     (clk_rx),
    .reset_n_rx (reset_n_rx),
    .sent_i     (sent_i),
    .status_o   (status_o),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .crc_err_o  (crc_err_o),
    .frame_err_o(frame_err_o)
  );

  always #5 clk_rx = ~clk_rx;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] model_crc(input logic [23:0] d);
    logic [3:0] c;
    c = 4'h5;
    for (int i = 5; i >= 0; i--) c = d[i*4 +: 4] ^ CrcTab[c];
    return CrcTab[c];
  endfunction

  // Fall, 5 ticks low, then high until the interval of ticks*TickClks+adj clocks is done.
  task automatic send_interval(input int ticks, input int adj);
    sent_i = 1'b0;
    t_fall = $time;
    repeat (5 * TickClks) @(negedge clk_rx);
    sent_i = 1'b1;
    repeat (ticks * int'(TickClks) + adj - 5 * int'(TickClks)) @(negedge clk_rx);
  endtask

  task automatic send_frame(input logic [3:0] st, input logic [23:0] d, input int crc_delta,
                            input int bad_idx, input int adj);
    logic [3:0] crc;
    crc = model_crc(d) + 4'(crc_delta);
    send_interval(56, adj);
    send_interval(12 + int'(st), adj);
    for (int i = 0; i < 6; i++) begin
      if (i == bad_idx) begin
        exp_q.push_back('{KFrame, good_st, good_data});
        send_interval(30, adj);
        return;
      end
      send_interval(12 + int'(d[(5-i)*4 +: 4]), adj);
    end
    if (crc_delta == 0) begin
      good_st   = st;
      good_data = d;
      exp_q.push_back('{KValid, st, d});
    end else begin
      exp_q.push_back('{KCrc, good_st, good_data});
    end
    send_interval(12 + int'(crc), adj);
  endtask

  always @(negedge clk_rx) begin
    if (valid_o || crc_err_o || frame_err_o) begin
      check_eq("one_hot", 32'($countones({valid_o, crc_err_o, frame_err_o})), 32'd1);
      mon_kind = valid_o ? KValid : (crc_err_o ? KCrc : KFrame);
      if (exp_q.size() == 0) begin
        check_eq("unexpected_pulse", 32'(mon_kind), 32'(KNone));
      end else begin
        mon_e = exp_q.pop_front();
        check_eq("kind", 32'(mon_kind), 32'(mon_e.kind));
        check_eq("status", 32'(status_o), 32'(mon_e.st));
        check_eq("data", 32'(data_o), 32'(mon_e.data));
        if (valid_o) check_eq("latency", 32'(($time - t_fall) / 10), 32'd4);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, pending %0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (5) @(negedge clk_rx);
    check_eq("rst_status", 32'(status_o), 32'd0);
    check_eq("rst_data", 32'(data_o), 32'd0);
    check_eq("rst_valid", 32'(valid_o), 32'd0);
    check_eq("rst_crc_err", 32'(crc_err_o), 32'd0);
    check_eq("rst_frame_err", 32'(frame_err_o), 32'd0);
    reset_n_rx = 1'b1;
    repeat (5 * TickClks) @(negedge clk_rx);

    send_frame(4'h0, 24'h123456, 0, -1, 0);   // good frame, CRC nibble 2
    send_frame(4'h0, 24'h123456, 1, -1, 0);   // CRC nibble 3 -> crc error
    send_frame(4'h7, 24'h001100, 0, -1, 0);   // recovers
    send_frame(4'h1, 24'h123456, 0, 2, 0);    // 30 ticks at data index 2
    send_frame(4'h0, 24'h123456, 0, -1, 24);  // stretched intervals
    send_frame(4'h0, 24'h123456, 0, -1, -25); // shrunk intervals

    // Sync, then line held low until the tick counter saturates.
    exp_q.push_back('{KFrame, good_st, good_data});
    send_interval(56, 0);
    sent_i = 1'b0;
    t_fall = $time;
    repeat (128 * TickClks) @(negedge clk_rx);
    check_eq("sat_pending", 32'(exp_q.size()), 32'd0);
    sent_i = 1'b1;
    repeat (5 * TickClks) @(negedge clk_rx);

    // Reset in the middle of data nibble 4.
    send_interval(56, 0);
    send_interval(12, 0);
    for (int i = 0; i < 4; i++) send_interval(13 + i, 0);
    sent_i = 1'b0;
    t_fall = $time;
    repeat (3 * TickClks) @(negedge clk_rx);
    #3 reset_n_rx = 1'b0;
    #1;
    check_eq("mid_rst_status", 32'(status_o), 32'd0);
    check_eq("mid_rst_data", 32'(data_o), 32'd0);
    check_eq("mid_rst_valid", 32'(valid_o), 32'd0);
    check_eq("mid_rst_crc_err", 32'(crc_err_o), 32'd0);
    check_eq("mid_rst_frame_err", 32'(frame_err_o), 32'd0);
    good_st   = 4'h0;
    good_data = 24'h0;
    repeat (10) @(negedge clk_rx);
    sent_i = 1'b1;
    repeat (10) @(negedge clk_rx);
    reset_n_rx = 1'b1;
    repeat (5 * TickClks) @(negedge clk_rx);

    send_frame(4'h2, 24'h210012, 0, -1, 0);
    send_interval(56, 0);                      // closes the last CRC nibble
    check_eq("drain_pending", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
